// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches over req/ack, issues with valid/ready,
// drives the NPC unit on the branch decision, checks targets, counts retires.
// Ports: clk, reset (async, active-high); imem_req/addr/ack/rdata;
// instr_valid/instr/instr_pc/instr_ready; br_valid/sel/zero;
// npc_pc/sel/zero/in; icount; fault/fault_cause/fault_pc.
// Option: define FETCH_TIMEOUT_EN to fault (cause 3) after TIMEOUT ack-less
// FETCH cycles; undefined, FETCH waits forever.
module fetch_sequencer #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] PC_MIN   = 32'h0000_3000,
  parameter logic [31:0] PC_MAX   = 32'h0000_6FFC,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        br_valid,
  input  logic [2:0]  br_sel,
  input  logic        br_zero,
  output logic [31:0] npc_pc,
  output logic [2:0]  npc_sel,
  output logic        npc_zero,
  input  logic [31:0] npc_in,
  output logic [31:0] icount,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_RESOLVE,
    S_FAULT
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc;
  logic        misaligned;
  logic        out_of_range;
  logic        timeout_hit;
  logic        resolve_go;

  assign misaligned   = |npc_in[1:0];
  assign out_of_range = (npc_in < PC_MIN) || (npc_in > PC_MAX);
  assign resolve_go   = (state == S_RESOLVE) && br_valid;

  assign imem_addr = pc;
  assign npc_pc    = pc;

`ifdef FETCH_TIMEOUT_EN
  logic [15:0] tcnt;

  // Cleared outside FETCH, so every entry starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (state != S_FETCH) begin
      tcnt <= '0;
    end else if (!imem_ack) begin
      tcnt <= tcnt + 16'd1;
    end
  end

  // tcnt holds the ack-less cycles already spent, so this is the
  // TIMEOUT-th one; an ack in the same cycle wins.
  assign timeout_hit = (state == S_FETCH) && !imem_ack &&
                       (tcnt == 16'(TIMEOUT - 1));
`else
  logic [31:0] timeout_unused;

  assign timeout_unused = TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          state_nx = S_ISSUE;
        end else if (timeout_hit) begin
          state_nx = S_FAULT;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          state_nx = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        if (br_valid) begin
          if (misaligned || out_of_range) begin
            state_nx = S_FAULT;
          end else begin
            state_nx = S_FETCH;
          end
        end
      end
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    npc_sel     = 3'd0;
    npc_zero    = 1'b0;
    fault       = 1'b0;
    unique case (state)
      S_FETCH: imem_req = 1'b1;
      S_ISSUE: instr_valid = 1'b1;
      S_RESOLVE: begin
        if (br_valid) begin
          npc_sel  = br_sel;
          npc_zero = br_zero;
        end
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= PC_RESET;
      instr       <= '0;
      instr_pc    <= '0;
      icount      <= '0;
      fault_cause <= 2'd0;
      fault_pc    <= '0;
    end else begin
      if ((state == S_FETCH) && imem_ack) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
      if (timeout_hit) begin
        fault_cause <= 2'd3;
        fault_pc    <= pc;
      end
      // Misalignment outranks the range check.
      if (resolve_go) begin
        if (misaligned) begin
          fault_cause <= 2'd1;
          fault_pc    <= npc_in;
        end else if (out_of_range) begin
          fault_cause <= 2'd2;
          fault_pc    <= npc_in;
        end else begin
          pc     <= npc_in;
          icount <= icount + 32'd1;
        end
      end
    end
  end

endmodule
